// File: rtl/shield_damage_sequencer.sv
// Shield damage sequencer: queues shot/bomb hits, erodes a pixel diamond per hit one cell
// per cycle, and reloads every shield row-by-row when a game starts.
module shield_damage_sequencer #(
  parameter int NUM_SHIELDS = 4,
  parameter int ROWS        = 16,
  parameter int COLS        = 32,
  parameter int RADIUS      = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           playGame_i,
  input  logic                           playerReq_i,
  input  logic [$clog2(NUM_SHIELDS)-1:0] playerShield_i,
  input  logic [$clog2(ROWS)-1:0]        playerRow_i,
  input  logic [$clog2(COLS)-1:0]        playerCol_i,
  input  logic                           bombReq_i,
  input  logic [$clog2(NUM_SHIELDS)-1:0] bombShield_i,
  input  logic [$clog2(ROWS)-1:0]        bombRow_i,
  input  logic [$clog2(COLS)-1:0]        bombCol_i,
  output logic                           playerAck_o,
  output logic                           bombAck_o,
  output logic                           eraseEn_o,
  output logic [$clog2(NUM_SHIELDS)-1:0] eraseShield_o,
  output logic [$clog2(ROWS)-1:0]        eraseRow_o,
  output logic [$clog2(COLS)-1:0]        eraseCol_o,
  output logic                           loadEn_o,
  output logic [$clog2(NUM_SHIELDS)-1:0] loadShield_o,
  output logic [$clog2(ROWS)-1:0]        loadRow_o,
  output logic                           busy_o,
  output logic                           fifoFull_o
);

  localparam int SW  = $clog2(NUM_SHIELDS);
  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int HW  = SW + RW + CW;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = $clog2(NUM_SHIELDS * ROWS);
  localparam int OW  = $clog2(RADIUS + 1) + 2;
  localparam int RXW = RW + 2;
  localparam int CXW = CW + 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RELOAD = 2'd1;
  localparam logic [1:0] ERODE  = 2'd2;

  localparam logic signed [OW-1:0] RAD       = OW'(RADIUS);
  localparam logic [LW-1:0]        LOAD_LAST = LW'(NUM_SHIELDS * ROWS - 1);
  localparam logic [PW:0]          FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

  logic [1:0]           state_q, state_d;
  logic                 playPrev_q;
  logic [LW-1:0]        loadCnt_q, loadCnt_d;
  logic [HW-1:0]        cur_q, cur_d;
  logic signed [OW-1:0] dr_q, dr_d, dc_q, dc_d;
  logic [HW-1:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wrPtr_q, rdPtr_q;
  logic [PW:0]          count_q, count_d;
  logic                 prioPlayer_q;

  logic                 playerAck_q, bombAck_q, eraseEn_q, loadEn_q, busy_q, fifoFull_q;
  logic [SW-1:0]        eraseShield_q, loadShield_q;
  logic [RW-1:0]        eraseRow_q, loadRow_q;
  logic [CW-1:0]        eraseCol_q;

  logic                 rise, flush, outOk, pop, push, canAccept;
  logic                 playerElig, bombElig, grantPlayer, grantBomb;
  logic                 rowEnd, lastCell, cellIn, eraseEn_d, loadEn_d;
  logic [HW-1:0]        pushData;
  logic signed [OW-1:0] absDr, drNext, absDrNext;
  logic signed [RXW-1:0] cellRow;
  logic signed [CXW-1:0] cellCol;

  // Diamond walk, FSM, and arbitration; a falling or rising playGame overrides everything.
  always_comb begin
    rise      = playGame_i & ~playPrev_q;
    flush     = ~playGame_i | rise;
    outOk     = playGame_i & ~rise;
    state_d   = state_q;
    loadCnt_d = loadCnt_q;
    cur_d     = cur_q;
    dr_d      = dr_q;
    dc_d      = dc_q;
    pop       = 1'b0;

    absDr     = dr_q[OW-1] ? -dr_q : dr_q;
    drNext    = dr_q + OW'(1);
    absDrNext = drNext[OW-1] ? -drNext : drNext;
    rowEnd    = (dc_q == RAD - absDr);
    lastCell  = (dr_q == RAD);

    cellRow = $signed({2'b00, cur_q[CW +: RW]}) + RXW'(dr_q);
    cellCol = $signed({2'b00, cur_q[CW-1:0]}) + CXW'(dc_q);
    cellIn  = ~cellRow[RXW-1] && (cellRow < RXW'(ROWS)) &&
              ~cellCol[CXW-1] && (cellCol < CXW'(COLS));

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ERODE;
        end
      end
      RELOAD: begin
        if (loadCnt_q == LOAD_LAST) state_d = IDLE;
        else                        loadCnt_d = loadCnt_q + LW'(1);
      end
      ERODE: begin
        if (!rowEnd) begin
          dc_d = dc_q + OW'(1);
        end else if (!lastCell) begin
          dr_d = drNext;
          dc_d = absDrNext - RAD;
        end else if (count_q != '0) begin
          pop = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      cur_d = mem_q[rdPtr_q];
      dr_d  = -RAD;
      dc_d  = '0;
    end

    if (rise) begin
      state_d   = RELOAD;
      loadCnt_d = '0;
      pop       = 1'b0;
    end else if (!playGame_i) begin
      state_d = IDLE;
      pop     = 1'b0;
    end

    // A full queue can still accept when the head leaves on the same edge.
    canAccept   = outOk && (state_q != RELOAD) && ((count_q != FULL_CNT) || pop);
    playerElig  = canAccept & playerReq_i & ~playerAck_q;
    bombElig    = canAccept & bombReq_i & ~bombAck_q;
    grantPlayer = playerElig & (~bombElig | prioPlayer_q);
    grantBomb   = bombElig & ~grantPlayer;
    push        = grantPlayer | grantBomb;
    pushData    = grantPlayer ? {playerShield_i, playerRow_i, playerCol_i}
                              : {bombShield_i, bombRow_i, bombCol_i};

    count_d   = flush ? '0 : count_q + (PW + 1)'(push) - (PW + 1)'(pop);
    eraseEn_d = outOk && (state_q == ERODE) && cellIn;
    loadEn_d  = outOk && (state_q == RELOAD);
  end

  // playPrev resets high so a game already running across reset does not trigger a reload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      playPrev_q    <= 1'b1;
      loadCnt_q     <= '0;
      cur_q         <= '0;
      dr_q          <= '0;
      dc_q          <= '0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      prioPlayer_q  <= 1'b1;
      playerAck_q   <= 1'b0;
      bombAck_q     <= 1'b0;
      eraseEn_q     <= 1'b0;
      eraseShield_q <= '0;
      eraseRow_q    <= '0;
      eraseCol_q    <= '0;
      loadEn_q      <= 1'b0;
      loadShield_q  <= '0;
      loadRow_q     <= '0;
      busy_q        <= 1'b0;
      fifoFull_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      playPrev_q <= playGame_i;
      loadCnt_q  <= loadCnt_d;
      cur_q      <= cur_d;
      dr_q       <= dr_d;
      dc_q       <= dc_d;
      count_q    <= count_d;
      if (flush) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
      end else begin
        if (push) wrPtr_q <= wrPtr_q + PW'(1);
        if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
      end
      if (grantPlayer)    prioPlayer_q <= 1'b0;
      else if (grantBomb) prioPlayer_q <= 1'b1;
      playerAck_q   <= grantPlayer;
      bombAck_q     <= grantBomb;
      eraseEn_q     <= eraseEn_d;
      eraseShield_q <= eraseEn_d ? cur_q[CW+RW +: SW] : '0;
      eraseRow_q    <= eraseEn_d ? cellRow[RW-1:0] : '0;
      eraseCol_q    <= eraseEn_d ? cellCol[CW-1:0] : '0;
      loadEn_q      <= loadEn_d;
      loadShield_q  <= loadEn_d ? loadCnt_q[LW-1 -: SW] : '0;
      loadRow_q     <= loadEn_d ? loadCnt_q[RW-1:0] : '0;
      busy_q        <= playGame_i & ((state_q != IDLE) | (count_q != '0));
      fifoFull_q    <= (count_d == FULL_CNT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wrPtr_q] <= pushData;
  end

  assign playerAck_o   = playerAck_q;
  assign bombAck_o     = bombAck_q;
  assign eraseEn_o     = eraseEn_q;
  assign eraseShield_o = eraseShield_q;
  assign eraseRow_o    = eraseRow_q;
  assign eraseCol_o    = eraseCol_q;
  assign loadEn_o      = loadEn_q;
  assign loadShield_o  = loadShield_q;
  assign loadRow_o     = loadRow_q;
  assign busy_o        = busy_q;
  assign fifoFull_o    = fifoFull_q;

endmodule

// File: tb/tb_shield_damage_sequencer.sv
// Directed bench for shield_damage_sequencer: reload sweep, diamond erosion, edge clipping,
// round-robin arbitration, queue back-pressure, abort and async reset.
module tb_shield_damage_sequencer;

  logic       clk = 1'b0;
  logic       rstN, playGame, playerReq, bombReq;
  logic [1:0] playerShield, bombShield;
  logic [3:0] playerRow, bombRow;
  logic [4:0] playerCol, bombCol;
  logic       playerAck, bombAck, eraseEn, loadEn, busy, fifoFull;
  logic [1:0] eraseShield, loadShield;
  logic [3:0] eraseRow, loadRow;
  logic [4:0] eraseCol;

  int passCnt = 0;
  int totalCnt = 0;
  int cyc = 0;
  bit autoDrop = 1'b0;

  int          ackStep[$];
  int          ackWho[$];
  int          eStep[$];
  logic [10:0] eCell[$];

  int dDr[13] = '{-2, -1, -1, -1, 0, 0, 0, 0, 0, 1, 1, 1, 2};
  int dDc[13] = '{0, -1, 0, 1, -2, -1, 0, 1, 2, -1, 0, 1, 0};

  shield_damage_sequencer dut (
    .clk_i(clk), .rst_ni(rstN), .playGame_i(playGame),
    .playerReq_i(playerReq), .playerShield_i(playerShield), .playerRow_i(playerRow),
    .playerCol_i(playerCol),
    .bombReq_i(bombReq), .bombShield_i(bombShield), .bombRow_i(bombRow), .bombCol_i(bombCol),
    .playerAck_o(playerAck), .bombAck_o(bombAck),
    .eraseEn_o(eraseEn), .eraseShield_o(eraseShield), .eraseRow_o(eraseRow),
    .eraseCol_o(eraseCol),
    .loadEn_o(loadEn), .loadShield_o(loadShield), .loadRow_o(loadRow),
    .busy_o(busy), .fifoFull_o(fifoFull)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    ackStep.delete();
    ackWho.delete();
    eStep.delete();
    eCell.delete();
  endtask

  // Advances n cycles, logging acks and erasures; optionally drops a request once acked.
  task automatic run_window(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (playerAck) begin
        ackStep.push_back(cyc);
        ackWho.push_back(0);
        if (autoDrop) playerReq = 1'b0;
      end
      if (bombAck) begin
        ackStep.push_back(cyc);
        ackWho.push_back(1);
        if (autoDrop) bombReq = 1'b0;
      end
      if (eraseEn) begin
        eStep.push_back(cyc);
        eCell.push_back({eraseShield, eraseRow, eraseCol});
      end
    end
  endtask

  task automatic test_reset();
    logic [9:0] outs;
    rstN = 1'b1; playGame = 1'b0; playerReq = 1'b0; bombReq = 1'b0;
    playerShield = '0; playerRow = '0; playerCol = '0;
    bombShield = '0; bombRow = '0; bombCol = '0;
    #3 rstN = 1'b0;
    #2;
    outs = {playerAck, bombAck, eraseEn, loadEn, busy, fifoFull, eraseShield, loadShield};
    totalCnt++;
    if (outs !== 10'd0) $display("[TB] FAIL reset_outputs: got %b expected 0", outs);
    else passCnt++;
    repeat (3) step();
    rstN = 1'b1;
    repeat (3) step();
    outs = {playerAck, bombAck, eraseEn, loadEn, busy, fifoFull, eraseRow, 1'b0};
    totalCnt++;
    if (outs !== 10'd0) $display("[TB] FAIL idle_after_reset: got %b expected 0", outs);
    else passCnt++;
  endtask

  task automatic test_reload();
    int firstLoad = -1, loadCount = 0, coordErr = 0, ackAt = -1, lastLoad = -1;
    logic busyAtLast = 1'b0, busyAfterLast = 1'b1;
    playerShield = 2'd2; playerRow = 4'd3; playerCol = 5'd4;
    playerReq = 1'b1; playGame = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      step();
      if (loadEn) begin
        if (firstLoad < 0) firstLoad = i;
        if ({loadShield, loadRow} !== 6'(loadCount)) coordErr++;
        loadCount++;
        lastLoad = i;
        busyAtLast = busy;
      end else if (lastLoad > 0 && lastLoad == i - 1) begin
        busyAfterLast = busy;
      end
      if (playerAck && ackAt < 0) begin
        ackAt = i;
        playerReq = 1'b0;
      end
    end
    totalCnt++;
    if (firstLoad !== 2) $display("[TB] FAIL reload_first_cycle: got %0d expected 2", firstLoad);
    else passCnt++;
    totalCnt++;
    if (loadCount !== 64) $display("[TB] FAIL reload_length: got %0d expected 64", loadCount);
    else passCnt++;
    totalCnt++;
    if (lastLoad - firstLoad + 1 !== 64)
      $display("[TB] FAIL reload_contiguous: got span %0d expected 64", lastLoad - firstLoad + 1);
    else passCnt++;
    totalCnt++;
    if (coordErr !== 0) $display("[TB] FAIL reload_order: got %0d bad rows expected 0", coordErr);
    else passCnt++;
    totalCnt++;
    if (busyAtLast !== 1'b1) $display("[TB] FAIL busy_last_load: got %b expected 1", busyAtLast);
    else passCnt++;
    totalCnt++;
    if (busyAfterLast !== 1'b0)
      $display("[TB] FAIL busy_after_reload: got %b expected 0", busyAfterLast);
    else passCnt++;
    totalCnt++;
    if (ackAt !== 66) $display("[TB] FAIL no_ack_in_reload: ack at %0d expected 66", ackAt);
    else passCnt++;
    repeat (10) step();
  endtask

  task automatic test_single_hit();
    int err = 0;
    int a0, e0, e12;
    logic [10:0] c0, c6, c12, expCell;
    clear_log();
    autoDrop = 1'b1;
    playerShield = 2'd1; playerRow = 4'd8; playerCol = 5'd16; playerReq = 1'b1;
    run_window(25);
    a0  = (ackStep.size() > 0) ? ackStep[0] : -100;
    e0  = (eStep.size() > 0) ? eStep[0] : -1;
    e12 = (eStep.size() > 12) ? eStep[12] : -1;
    c0  = (eCell.size() > 0) ? eCell[0] : 11'h7ff;
    c6  = (eCell.size() > 6) ? eCell[6] : 11'h7ff;
    c12 = (eCell.size() > 12) ? eCell[12] : 11'h7ff;
    for (int i = 0; i < 13; i++) begin
      expCell = {2'd1, 4'(8 + dDr[i]), 5'(16 + dDc[i])};
      if (i >= eCell.size() || eCell[i] !== expCell) err++;
    end
    totalCnt++;
    if (ackStep.size() !== 1) $display("[TB] FAIL single_ack_count: got %0d expected 1", ackStep.size());
    else passCnt++;
    totalCnt++;
    if (eStep.size() !== 13) $display("[TB] FAIL single_erase_count: got %0d expected 13", eStep.size());
    else passCnt++;
    totalCnt++;
    if (e0 - a0 !== 2) $display("[TB] FAIL single_latency: got %0d expected 2", e0 - a0);
    else passCnt++;
    totalCnt++;
    if (e12 - e0 !== 12) $display("[TB] FAIL single_contiguous: got %0d expected 12", e12 - e0);
    else passCnt++;
    totalCnt++;
    if (c0 !== {2'd1, 4'd6, 5'd16}) $display("[TB] FAIL single_first_cell: got %h expected %h", c0, {2'd1, 4'd6, 5'd16});
    else passCnt++;
    totalCnt++;
    if (c6 !== {2'd1, 4'd8, 5'd16}) $display("[TB] FAIL single_center_cell: got %h expected %h", c6, {2'd1, 4'd8, 5'd16});
    else passCnt++;
    totalCnt++;
    if (c12 !== {2'd1, 4'd10, 5'd16}) $display("[TB] FAIL single_last_cell: got %h expected %h", c12, {2'd1, 4'd10, 5'd16});
    else passCnt++;
    totalCnt++;
    if (err !== 0) $display("[TB] FAIL single_diamond_set: got %0d wrong cells expected 0", err);
    else passCnt++;
  endtask

  task automatic test_corner_hits();
    logic [10:0] cellsA[6] = '{{2'd0, 4'd0, 5'd0}, {2'd0, 4'd0, 5'd1}, {2'd0, 4'd0, 5'd2},
                               {2'd0, 4'd1, 5'd0}, {2'd0, 4'd1, 5'd1}, {2'd0, 4'd2, 5'd0}};
    int offsA[6] = '{8, 9, 10, 12, 13, 14};
    logic [10:0] cellsB[6] = '{{2'd0, 4'd13, 5'd31}, {2'd0, 4'd14, 5'd30}, {2'd0, 4'd14, 5'd31},
                               {2'd0, 4'd15, 5'd29}, {2'd0, 4'd15, 5'd30}, {2'd0, 4'd15, 5'd31}};
    int offsB[6] = '{2, 3, 4, 6, 7, 8};
    for (int h = 0; h < 2; h++) begin
      int err = 0;
      int a0;
      clear_log();
      autoDrop = 1'b1;
      bombShield = 2'd0;
      bombRow = (h == 0) ? 4'd0 : 4'd15;
      bombCol = (h == 0) ? 5'd0 : 5'd31;
      bombReq = 1'b1;
      run_window(25);
      a0 = (ackStep.size() > 0) ? ackStep[0] : -100;
      for (int i = 0; i < 6; i++) begin
        if (i >= eCell.size()) err++;
        else if (eCell[i] !== ((h == 0) ? cellsA[i] : cellsB[i])) err++;
        else if (eStep[i] - a0 !== ((h == 0) ? offsA[i] : offsB[i])) err++;
      end
      totalCnt++;
      if (ackStep.size() !== 1) $display("[TB] FAIL corner%0d_ack_count: got %0d expected 1", h, ackStep.size());
      else passCnt++;
      totalCnt++;
      if (eStep.size() !== 6) $display("[TB] FAIL corner%0d_erase_count: got %0d expected 6", h, eStep.size());
      else passCnt++;
      totalCnt++;
      if (err !== 0) $display("[TB] FAIL corner%0d_cells: got %0d wrong cells expected 0", h, err);
      else passCnt++;
    end
  endtask

  task automatic test_back_to_back();
    int altErr = 0, ctrErr = 0, pCount = 0, bCount = 0, span, idx;
    logic [10:0] expCtr;
    clear_log();
    autoDrop = 1'b0;
    playerShield = 2'd2; playerRow = 4'd5; playerCol = 5'd10;
    bombShield = 2'd3; bombRow = 4'd9; bombCol = 5'd20;
    playerReq = 1'b1; bombReq = 1'b1;
    run_window(60);
    playerReq = 1'b0; bombReq = 1'b0;
    run_window(100);
    for (int i = 0; i < ackWho.size(); i++) begin
      if (ackWho[i] !== (i % 2)) altErr++;
      if (ackWho[i] == 0) pCount++;
      else bCount++;
      idx = 13 * i + 6;
      expCtr = (ackWho[i] == 0) ? {2'd2, 4'd5, 5'd10} : {2'd3, 4'd9, 5'd20};
      if (idx >= eCell.size() || eCell[idx] !== expCtr) ctrErr++;
    end
    span = (eStep.size() > 0) ? eStep[eStep.size() - 1] - eStep[0] + 1 : 0;
    totalCnt++;
    if (altErr !== 0) $display("[TB] FAIL rr_alternate: got %0d out-of-order acks expected 0", altErr);
    else passCnt++;
    totalCnt++;
    if (pCount !== 5) $display("[TB] FAIL rr_player_acks: got %0d expected 5", pCount);
    else passCnt++;
    totalCnt++;
    if (bCount !== 4) $display("[TB] FAIL rr_bomb_acks: got %0d expected 4", bCount);
    else passCnt++;
    totalCnt++;
    if (eStep.size() !== 13 * ackStep.size())
      $display("[TB] FAIL b2b_erase_total: got %0d expected %0d", eStep.size(), 13 * ackStep.size());
    else passCnt++;
    totalCnt++;
    if (span !== eStep.size()) $display("[TB] FAIL b2b_no_bubble: got span %0d expected %0d", span, eStep.size());
    else passCnt++;
    totalCnt++;
    if (ctrErr !== 0) $display("[TB] FAIL b2b_centers: got %0d wrong centers expected 0", ctrErr);
    else passCnt++;
    totalCnt++;
    if (busy !== 1'b0) $display("[TB] FAIL b2b_drained: busy got %b expected 0", busy);
    else passCnt++;
  endtask

  task automatic test_fifo_full();
    int acks[$];
    logic full[17];
    int expAcks[6] = '{1, 3, 5, 7, 9, 15};
    int err = 0;
    bombShield = 2'd1; bombRow = 4'd8; bombCol = 5'd16; bombReq = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (bombAck) acks.push_back(i);
      full[i] = fifoFull;
    end
    bombReq = 1'b0;
    for (int i = 0; i < 6; i++) if (i >= acks.size() || acks[i] !== expAcks[i]) err++;
    totalCnt++;
    if (acks.size() !== 6) $display("[TB] FAIL full_ack_count: got %0d expected 6", acks.size());
    else passCnt++;
    totalCnt++;
    if (err !== 0) $display("[TB] FAIL full_ack_timing: got %0d misplaced acks expected 0", err);
    else passCnt++;
    totalCnt++;
    if (full[8] !== 1'b0) $display("[TB] FAIL full_before: got %b expected 0", full[8]);
    else passCnt++;
    totalCnt++;
    if (full[9] !== 1'b1) $display("[TB] FAIL full_reached: got %b expected 1", full[9]);
    else passCnt++;
    totalCnt++;
    if (full[15] !== 1'b1) $display("[TB] FAIL full_push_pop: got %b expected 1", full[15]);
    else passCnt++;
  endtask

  task automatic test_abort();
    int eraseCount = 0, loadCount = 0, firstLoad = -1;
    repeat (3) step();
    totalCnt++;
    if (eraseEn !== 1'b1) $display("[TB] FAIL abort_mid_erode: eraseEn got %b expected 1", eraseEn);
    else passCnt++;
    playGame = 1'b0;
    step();
    totalCnt++;
    if ({eraseEn, busy, fifoFull, loadEn} !== 4'b0000)
      $display("[TB] FAIL abort_outputs: got %b expected 0000", {eraseEn, busy, fifoFull, loadEn});
    else passCnt++;
    for (int i = 0; i < 10; i++) begin
      step();
      if (eraseEn) eraseCount++;
    end
    playGame = 1'b1;
    for (int i = 1; i <= 90; i++) begin
      step();
      if (eraseEn) eraseCount++;
      if (loadEn) begin
        if (firstLoad < 0) firstLoad = i;
        loadCount++;
      end
    end
    totalCnt++;
    if (eraseCount !== 0) $display("[TB] FAIL abort_stale_erase: got %0d expected 0", eraseCount);
    else passCnt++;
    totalCnt++;
    if (firstLoad !== 2) $display("[TB] FAIL abort_reload_start: got %0d expected 2", firstLoad);
    else passCnt++;
    totalCnt++;
    if (loadCount !== 64) $display("[TB] FAIL abort_reload_length: got %0d expected 64", loadCount);
    else passCnt++;
    totalCnt++;
    if ({busy, fifoFull} !== 2'b00) $display("[TB] FAIL abort_flushed: got %b expected 00", {busy, fifoFull});
    else passCnt++;
  endtask

  task automatic test_async_reset();
    int loadCount = 0;
    playGame = 1'b0;
    step();
    playGame = 1'b1;
    repeat (10) step();
    totalCnt++;
    if (loadEn !== 1'b1) $display("[TB] FAIL areset_reload_running: got %b expected 1", loadEn);
    else passCnt++;
    #2 rstN = 1'b0;
    #1;
    totalCnt++;
    if ({loadEn, busy, eraseEn, loadRow} !== 7'd0)
      $display("[TB] FAIL areset_immediate: got %b expected 0", {loadEn, busy, eraseEn, loadRow});
    else passCnt++;
    #2 rstN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (loadEn) loadCount++;
    end
    totalCnt++;
    if (loadCount !== 0) $display("[TB] FAIL areset_no_reload: got %0d expected 0", loadCount);
    else passCnt++;
  endtask

  initial begin
    test_reset();
    test_reload();
    test_single_hit();
    test_corner_hits();
    test_back_to_back();
    test_fifo_full();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
